// File: rtl/ins_cache_refill.sv
// -----------------------------------------------------------------------------
// ins_cache_refill
//
// Line refill engine for the instruction cache. On a miss it reads one cache
// line from main instruction memory, starting with the missed (critical) word
// and wrapping modulo the line length. Each returned word is written into the
// I-cache data array. The critical word is also forwarded to the fetch path
// as soon as it arrives, unless a pipeline flush has been seen during the
// refill. After the last word the tag/valid entry is written and done pulses.
//
// Ports
//   ins_cache_refill_clock_in        clock, rising edge
//   ins_cache_refill_reset_in        asynchronous active-low reset
//   ins_cache_refill_req_in          miss request (level, held until done)
//   ins_cache_refill_addr_in         missed byte address
//   ins_cache_refill_flush_in        pipeline flush, suppresses the forward
//   ins_cache_refill_busy_out        refill in progress (FILL or TAG)
//   ins_cache_refill_done_out        1-cycle pulse: line and tag written
//   ins_cache_refill_crit_valid_out  1-cycle pulse: critical word valid
//   ins_cache_refill_crit_data_out   critical word
//   ins_mem_req_out / _addr_out      memory read request, word-aligned address
//   ins_mem_gnt_in                   request accepted (req & gnt = issue)
//   ins_mem_rvalid_in / _rdata_in    in-order read response
//   ins_cache_we_out                 data-array write enable
//   ins_cache_index_out              line index for data and tag writes
//   ins_cache_word_out               word within line
//   ins_cache_data_out               word to write
//   ins_cache_tag_we_out             tag-array write enable (sets valid)
//   ins_cache_tag_out                tag to write
// -----------------------------------------------------------------------------
module ins_cache_refill #(
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int INDEX_BITS     = 6,
  localparam int OFF_BITS       = $clog2(WORDS_PER_LINE) + 2,
  localparam int WORD_BITS      = OFF_BITS - 2,
  localparam int TAG_W          = ADDR_WIDTH - INDEX_BITS - OFF_BITS
) (
  input  logic                  ins_cache_refill_clock_in,
  input  logic                  ins_cache_refill_reset_in,
  input  logic                  ins_cache_refill_req_in,
  input  logic [ADDR_WIDTH-1:0] ins_cache_refill_addr_in,
  input  logic                  ins_cache_refill_flush_in,
  output logic                  ins_cache_refill_busy_out,
  output logic                  ins_cache_refill_done_out,
  output logic                  ins_cache_refill_crit_valid_out,
  output logic [DATA_WIDTH-1:0] ins_cache_refill_crit_data_out,
  output logic                  ins_mem_req_out,
  output logic [ADDR_WIDTH-1:0] ins_mem_addr_out,
  input  logic                  ins_mem_gnt_in,
  input  logic                  ins_mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0] ins_mem_rdata_in,
  output logic                  ins_cache_we_out,
  output logic [INDEX_BITS-1:0] ins_cache_index_out,
  output logic [WORD_BITS-1:0]  ins_cache_word_out,
  output logic [DATA_WIDTH-1:0] ins_cache_data_out,
  output logic                  ins_cache_tag_we_out,
  output logic [TAG_W-1:0]      ins_cache_tag_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_TAG
  } state_t;

  localparam logic [WORD_BITS:0] CNT_ONE = 1;

  state_t                 state;
  logic [TAG_W-1:0]       tag_q;
  logic [INDEX_BITS-1:0]  index_q;
  logic [WORD_BITS-1:0]   crit_q;
  // One bit wider than a word offset so that "all N done" is the MSB.
  logic [WORD_BITS:0]     issued_q;
  logic [WORD_BITS:0]     recvd_q;
  logic                   flush_q;

  logic [WORD_BITS-1:0]   issue_word;
  logic [WORD_BITS-1:0]   recv_word;
  logic                   issue_fire;
  logic                   recv_accept;
  logic                   recv_last;

  // Byte-offset bits of the missed address never reach the memory port.
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^ins_cache_refill_addr_in[1:0];

  // Word order wraps modulo the line length: the WORD_BITS-wide sum drops
  // the carry, so crit+k naturally rolls back to word 0.
  always_comb begin
    issue_word = crit_q + issued_q[WORD_BITS-1:0];
    recv_word  = crit_q + recvd_q[WORD_BITS-1:0];
  end

  // Memory request is decoded from registered state so a grant can be taken
  // every cycle without a bubble.
  assign ins_mem_req_out  = (state == ST_FILL) && !issued_q[WORD_BITS];
  assign ins_mem_addr_out = ins_mem_req_out ? {tag_q, index_q, issue_word, 2'b00}
                                            : '0;

  assign issue_fire  = ins_mem_req_out && ins_mem_gnt_in;
  // Responses are only taken while words are still owed; stray pulses in
  // IDLE/TAG or beyond the N-th word are dropped.
  assign recv_accept = (state == ST_FILL) && ins_mem_rvalid_in && !recvd_q[WORD_BITS];
  assign recv_last   = (recvd_q[WORD_BITS-1:0] == '1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge ins_cache_refill_clock_in or negedge ins_cache_refill_reset_in) begin
    if (!ins_cache_refill_reset_in) begin
      // NOTE: datapath registers are reset too, not just control, because the
      // output ports must read zero while reset is held.
      state                           <= ST_IDLE;
      tag_q                           <= '0;
      index_q                         <= '0;
      crit_q                          <= '0;
      issued_q                        <= '0;
      recvd_q                         <= '0;
      flush_q                         <= 1'b0;
      ins_cache_refill_busy_out       <= 1'b0;
      ins_cache_refill_done_out       <= 1'b0;
      ins_cache_refill_crit_valid_out <= 1'b0;
      ins_cache_refill_crit_data_out  <= '0;
      ins_cache_we_out                <= 1'b0;
      ins_cache_index_out             <= '0;
      ins_cache_word_out              <= '0;
      ins_cache_data_out              <= '0;
      ins_cache_tag_we_out            <= 1'b0;
      ins_cache_tag_out               <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle; the branches below only
      // ever raise them, so each strobe lasts exactly one cycle.
      ins_cache_we_out                <= 1'b0;
      ins_cache_refill_crit_valid_out <= 1'b0;
      ins_cache_tag_we_out            <= 1'b0;
      ins_cache_refill_done_out       <= 1'b0;

      case (state)
        ST_IDLE: begin
          ins_cache_refill_busy_out <= 1'b0;
          if (ins_cache_refill_req_in) begin
            tag_q                     <= ins_cache_refill_addr_in[ADDR_WIDTH-1 -: TAG_W];
            index_q                   <= ins_cache_refill_addr_in[OFF_BITS +: INDEX_BITS];
            crit_q                    <= ins_cache_refill_addr_in[OFF_BITS-1:2];
            ins_cache_index_out       <= ins_cache_refill_addr_in[OFF_BITS +: INDEX_BITS];
            issued_q                  <= '0;
            recvd_q                   <= '0;
            flush_q                   <= 1'b0;
            ins_cache_refill_busy_out <= 1'b1;
            state                     <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (ins_cache_refill_flush_in) begin
            flush_q <= 1'b1;
          end
          if (issue_fire) begin
            issued_q <= issued_q + CNT_ONE;
          end
          if (recv_accept) begin
            ins_cache_we_out   <= 1'b1;
            ins_cache_word_out <= recv_word;
            ins_cache_data_out <= ins_mem_rdata_in;
            recvd_q            <= recvd_q + CNT_ONE;
            // The first response is always the critical word. A flush seen
            // in this very cycle suppresses it as well as an earlier one.
            if ((recvd_q == '0) && !flush_q && !ins_cache_refill_flush_in) begin
              ins_cache_refill_crit_valid_out <= 1'b1;
              ins_cache_refill_crit_data_out  <= ins_mem_rdata_in;
            end
            if (recv_last) begin
              ins_cache_tag_we_out      <= 1'b1;
              ins_cache_tag_out         <= tag_q;
              ins_cache_refill_done_out <= 1'b1;
              state                     <= ST_TAG;
            end
          end
        end

        ST_TAG: begin
          // Single-cycle state; the requester's still-high req is ignored
          // here and re-sampled once back in IDLE.
          if (ins_cache_refill_flush_in) begin
            flush_q <= 1'b1;
          end
          ins_cache_refill_busy_out <= 1'b0;
          state                     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_cache_refill.sv
// -----------------------------------------------------------------------------
// tb_ins_cache_refill
//
// Directed bench for ins_cache_refill. A small in-order memory model answers
// read requests (optional random grant stalls and response gaps), and a
// negedge monitor logs every issue, data write, critical forward, tag write
// and done pulse with its cycle number. Each directed step compares the logs
// against hand-computed addresses, words, indices, tags and cycle numbers.
//
// Cycle numbering: the refill request is first seen at edge 0, and cycle n is
// the cycle that follows edge n-1 (so memory requests occupy cycles 1..4).
// Address split at defaults: tag = addr[31:10], index = addr[9:4],
// word = addr[3:2]. 0x1234 -> tag 0x4, index 0x23, crit word 1.
// 0x2008 -> tag 0x8, index 0x00, crit word 2.
// -----------------------------------------------------------------------------
module tb_ins_cache_refill;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int IB = 6;
  localparam int WB = 2;
  localparam int TW = 22;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [AW-1:0] addr;
  logic          flush;
  logic          busy;
  logic          done;
  logic          crit_valid;
  logic [DW-1:0] crit_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          we;
  logic [IB-1:0] index;
  logic [WB-1:0] word;
  logic [DW-1:0] wdata;
  logic          tag_we;
  logic [TW-1:0] tag;

  ins_cache_refill #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .WORDS_PER_LINE(N),
    .INDEX_BITS    (IB)
  ) dut (
    .ins_cache_refill_clock_in      (clk),
    .ins_cache_refill_reset_in      (rst_n),
    .ins_cache_refill_req_in        (req),
    .ins_cache_refill_addr_in       (addr),
    .ins_cache_refill_flush_in      (flush),
    .ins_cache_refill_busy_out      (busy),
    .ins_cache_refill_done_out      (done),
    .ins_cache_refill_crit_valid_out(crit_valid),
    .ins_cache_refill_crit_data_out (crit_data),
    .ins_mem_req_out                (mem_req),
    .ins_mem_addr_out               (mem_addr),
    .ins_mem_gnt_in                 (gnt),
    .ins_mem_rvalid_in              (rvalid),
    .ins_mem_rdata_in               (rdata),
    .ins_cache_we_out               (we),
    .ins_cache_index_out            (index),
    .ins_cache_word_out             (word),
    .ins_cache_data_out             (wdata),
    .ins_cache_tag_we_out           (tag_we),
    .ins_cache_tag_out              (tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main-memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1357};
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] a;
    int          ready;
  } pend_t;

  typedef struct {
    int          c;
    logic [31:0] v;
    logic [3:0]  w;
    logic [21:0] t;
  } ev_t;

  pend_t pq[$];
  bit    gnt_rand = 1'b0;
  bit    gap_rand = 1'b0;
  int    flush_at = -1;
  int    spur_lo  = -1;
  int    spur_hi  = -1;

  initial begin : mem_model
    pend_t p;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    flush  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pq.delete();
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        flush  = 1'b0;
      end else begin
        gnt   = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        flush = (cyc == flush_at);
        if (pq.size() > 0 && pq[0].ready <= cyc) begin
          p      = pq.pop_front();
          rvalid = 1'b1;
          rdata  = mem_word(p.a);
        end else if (cyc >= spur_lo && cyc <= spur_hi) begin
          rvalid = 1'b1;
          rdata  = 32'hDEAD_BEEF;
        end else begin
          rvalid = 1'b0;
          rdata  = '0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  ev_t ilog[$];
  ev_t wlog[$];
  ev_t clog[$];
  ev_t tlog[$];
  int  dlog[$];
  bit  busy_at [0:4095];

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      busy_at[cyc & 4095] = busy;
      if (rst_n && mem_req && gnt) begin
        pq.push_back('{a: mem_addr, ready: cyc + 1 + (gap_rand ? int'($urandom_range(0, 3)) : 0)});
        e = '{c: cyc, v: mem_addr, w: 4'd0, t: 22'd0};
        ilog.push_back(e);
      end
      if (we) begin
        e = '{c: cyc, v: wdata, w: {2'b00, word}, t: {16'd0, index}};
        wlog.push_back(e);
      end
      if (crit_valid) begin
        e = '{c: cyc, v: crit_data, w: 4'd0, t: 22'd0};
        clog.push_back(e);
      end
      if (tag_we) begin
        e = '{c: cyc, v: {26'd0, index}, w: 4'd0, t: tag};
        tlog.push_back(e);
      end
      if (done) dlog.push_back(cyc);
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ilog.delete();
    wlog.delete();
    clog.delete();
    tlog.delete();
    dlog.delete();
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_busy"},       busy,       '0);
    check({nm, "_done"},       done,       '0);
    check({nm, "_crit_valid"}, crit_valid, '0);
    check({nm, "_crit_data"},  crit_data,  '0);
    check({nm, "_mem_req"},    mem_req,    '0);
    check({nm, "_mem_addr"},   mem_addr,   '0);
    check({nm, "_we"},         we,         '0);
    check({nm, "_index"},      index,      '0);
    check({nm, "_word"},       word,       '0);
    check({nm, "_wdata"},      wdata,      '0);
    check({nm, "_tag_we"},     tag_we,     '0);
    check({nm, "_tag"},        tag,        '0);
  endtask

  task automatic start_req(input logic [31:0] a, input int flush_rel, input int spur_rel,
                           output int base);
    @(posedge clk);
    #1;
    base     = cyc;
    req      = 1'b1;
    addr     = a;
    flush_at = (flush_rel >= 0) ? base + flush_rel : -1;
    if (spur_rel >= 0) begin
      spur_lo = base + spur_rel;
      spur_hi = base + spur_rel + 1;
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check({nm, "_done_seen"}, seen, 1);
  endtask

  task automatic drop_req();
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // Compare one complete refill against its expected issue order a0..a3.
  task automatic check_line(input string nm, input int base, input bit timed,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3,
                            input logic [5:0] eidx, input logic [21:0] etag,
                            input bit ecrit);
    logic [31:0] ea [4];
    ea[0] = a0;
    ea[1] = a1;
    ea[2] = a2;
    ea[3] = a3;
    check({nm, "_n_issue"}, ilog.size(), 4);
    for (int i = 0; i < 4 && i < ilog.size(); i++) begin
      check($sformatf("%s_issue%0d_addr", nm, i), ilog[i].v, ea[i]);
      if (timed) check($sformatf("%s_issue%0d_cyc", nm, i), ilog[i].c, base + 1 + i);
    end
    check({nm, "_n_write"}, wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      check($sformatf("%s_wr%0d_word", nm, i),  wlog[i].w, {2'b00, ea[i][3:2]});
      check($sformatf("%s_wr%0d_data", nm, i),  wlog[i].v, mem_word(ea[i]));
      check($sformatf("%s_wr%0d_index", nm, i), wlog[i].t, {16'd0, eidx});
      if (timed) check($sformatf("%s_wr%0d_cyc", nm, i), wlog[i].c, base + 3 + i);
    end
    if (ecrit) begin
      check({nm, "_n_crit"}, clog.size(), 1);
      if (clog.size() > 0) begin
        check({nm, "_crit_data"}, clog[0].v, mem_word(a0));
        if (timed) check({nm, "_crit_cyc"}, clog[0].c, base + 3);
      end
    end else begin
      check({nm, "_n_crit"}, clog.size(), 0);
    end
    check({nm, "_n_tag"}, tlog.size(), 1);
    if (tlog.size() > 0) begin
      check({nm, "_tag_val"},   tlog[0].t, etag);
      check({nm, "_tag_index"}, tlog[0].v, {26'd0, eidx});
      if (timed) check({nm, "_tag_cyc"}, tlog[0].c, base + 6);
    end
    check({nm, "_n_done"}, dlog.size(), 1);
    if (timed && dlog.size() > 0) check({nm, "_done_cyc"}, dlog[0], base + 6);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int base;
    rst_n = 1'b1;
    req   = 1'b0;
    addr  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1. Critical word 1 of line 0x1230, zero-stall memory, exact timing.
    clear_logs();
    start_req(32'h0000_1234, -1, -1, base);
    @(negedge clk);
    check("c1_busy_cyc0", busy, 0);
    wait_done("c1");
    drop_req();
    @(negedge clk);
    check("c1_busy_cyc1", busy_at[(base + 1) & 4095], 1);
    check("c1_busy_cyc6", busy_at[(base + 6) & 4095], 1);
    check("c1_busy_cyc7", busy, 0);
    check_line("c1", base, 1'b1, 32'h1234, 32'h1238, 32'h123C, 32'h1230,
               6'h23, 22'h4, 1'b1);

    // 2. Critical word 0, random grant stalls and response gaps.
    repeat (2) @(posedge clk);
    clear_logs();
    gnt_rand = 1'b1;
    gap_rand = 1'b1;
    start_req(32'h0000_1230, -1, -1, base);
    wait_done("c2");
    drop_req();
    gnt_rand = 1'b0;
    gap_rand = 1'b0;
    repeat (2) @(posedge clk);
    check_line("c2", base, 1'b0, 32'h1230, 32'h1234, 32'h1238, 32'h123C,
               6'h23, 22'h4, 1'b1);

    // 3. Flush in cycle 2, coincident with the critical response.
    clear_logs();
    start_req(32'h0000_1234, 2, -1, base);
    wait_done("c3");
    drop_req();
    repeat (2) @(posedge clk);
    check_line("c3", base, 1'b1, 32'h1234, 32'h1238, 32'h123C, 32'h1230,
               6'h23, 22'h4, 1'b0);

    // 4. Reset in mid-refill after two responses, then a fresh refill.
    clear_logs();
    start_req(32'h0000_1234, -1, -1, base);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    check_outputs_zero("c4_in_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_logs();
    start_req(32'h0000_2008, -1, -1, base);
    wait_done("c4");
    drop_req();
    repeat (2) @(posedge clk);
    check_line("c4", base, 1'b1, 32'h2008, 32'h200C, 32'h2000, 32'h2004,
               6'h00, 22'h8, 1'b1);

    // 5. Stray responses while idle, then in TAG and the following IDLE cycle.
    @(posedge clk);
    #1;
    clear_logs();
    spur_lo = cyc + 1;
    spur_hi = cyc + 3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("c5_idle_writes", wlog.size(), 0);
    check("c5_idle_busy", busy, 0);
    check("c5_idle_tag_we", tlog.size(), 0);
    clear_logs();
    start_req(32'h0000_1234, -1, 6, base);
    wait_done("c5");
    drop_req();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("c5_busy_after", busy, 0);
    check_line("c5", base, 1'b1, 32'h1234, 32'h1238, 32'h123C, 32'h1230,
               6'h23, 22'h4, 1'b1);
    spur_lo = -1;
    spur_hi = -1;

    // 6. Back-to-back: req held through done restarts from IDLE in cycle 7.
    @(posedge clk);
    clear_logs();
    start_req(32'h0000_1234, -1, -1, base);
    wait_done("c6a");
    wait_done("c6b");
    drop_req();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("c6_busy_cyc7", busy_at[(base + 7) & 4095], 0);
    check("c6_busy_cyc8", busy_at[(base + 8) & 4095], 1);
    check("c6_n_issue", ilog.size(), 8);
    check("c6_issue4_cyc",  (ilog.size() > 4) ? ilog[4].c : -1, base + 8);
    check("c6_issue4_addr", (ilog.size() > 4) ? ilog[4].v : 32'h0, 32'h1234);
    check("c6_n_write", wlog.size(), 8);
    check("c6_wr4_cyc",  (wlog.size() > 4) ? wlog[4].c : -1, base + 10);
    check("c6_wr7_word", (wlog.size() > 7) ? wlog[7].w : 4'hF, 4'h0);
    check("c6_n_done", dlog.size(), 2);
    check("c6_done2_cyc", (dlog.size() > 1) ? dlog[1] : -1, base + 13);
    check("c6_n_tag", tlog.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
